// File: rtl/spi_cmd_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_cmd_deframer                                           |
// | Description : SPI mode-0 slave front end for the LED/ADC command         |
// |               decoder. Receives 16-bit frames (byte0 = command,          |
// |               byte1 = data), hands each valid frame to the decoder as    |
// |               command/data followed by a clean enable strobe, flags      |
// |               rejected frames and echoes the last accepted frame on MISO.|
// |                                                                          |
// | Parameters  : SYNC_STAGES   (2..3) synchroniser depth for SPI pins       |
// |               SETUP_CYCLES  (>=1)  command/data settle time before strobe|
// |               ENABLE_CYCLES (>=1)  width of the enable strobe            |
// | Build macro : SPI_CMD_PARITY_EN - frame bit 15 is an even-parity bit     |
// |               over byte0; mismatching frames are rejected and the echo   |
// |               MSB carries regenerated parity. Undefined: bit 15 ignored, |
// |               echo MSB is 0.                                             |
// |                                                                          |
// | Ports       : clk, rst         system clock, sync active-high reset      |
// |               spi_sclk/mosi/cs_n  asynchronous SPI inputs from host      |
// |               spi_miso         echo of the last accepted frame           |
// |               command[6:0], data[7:0], enable  decoder interface        |
// |               frame_err        one-cycle pulse per rejected frame        |
// |               err_count[7:0]   saturating rejected-frame counter         |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_cmd_deframer #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETUP_CYCLES  = 2,
    parameter int ENABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic [6:0] command,
    output logic [7:0] data,
    output logic       enable,
    output logic       frame_err,
    output logic [7:0] err_count
);

    // The reserved MSB only needs storage when it carries parity; without
    // the check it simply falls off the top of the shifter.
`ifdef SPI_CMD_PARITY_EN
    localparam int c_SHIFT_W = 16;
`else
    localparam int c_SHIFT_W = 15;
`endif

    localparam int c_PH_MAX = (SETUP_CYCLES > ENABLE_CYCLES) ? SETUP_CYCLES : ENABLE_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_PH_W-1:0] c_SETUP_LAST  = c_PH_W'(SETUP_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_ENABLE_LAST = c_PH_W'(ENABLE_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_PH_ONE      = c_PH_W'(1);

    localparam logic [4:0] c_BITS_FULL = 5'd16;
    localparam logic [4:0] c_BITS_SAT  = 5'd17;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;

    // ------------------------------------------------------------------
    // Synchronisers and one-cycle-delayed copies.
    // These are pure data pipelines tracking the pins, so they are left
    // out of reset: a reset taken while cs_n is low must not fabricate a
    // cs_n falling edge when it releases.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_mosi_q;

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_s;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
        r_sclk_d    <= w_sclk_s;
        r_cs_d      <= w_cs_s;
        // Delayed so MOSI lines up with the registered sclk-rise pulse.
        r_mosi_q    <= w_mosi_s;
    end

    // ------------------------------------------------------------------
    // Registered edge pulses.
    // r_cs_was_low is cs_n as seen *before* the sample that produced the
    // current pulses, so an sclk rise coinciding with the cs_n rise still
    // counts, while one coinciding with the cs_n fall does not.
    // ------------------------------------------------------------------
    logic r_sclk_rise;
    logic r_sclk_fall;
    logic r_cs_rise;
    logic r_cs_fall;
    logic r_cs_was_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_rise  <= 1'b0;
            r_sclk_fall  <= 1'b0;
            r_cs_rise    <= 1'b0;
            r_cs_fall    <= 1'b0;
            r_cs_was_low <= 1'b0;
        end else begin
            r_sclk_rise  <= w_sclk_s & ~r_sclk_d;
            r_sclk_fall  <= ~w_sclk_s & r_sclk_d;
            r_cs_rise    <= w_cs_s & ~r_cs_d;
            r_cs_fall    <= ~w_cs_s & r_cs_d;
            r_cs_was_low <= ~r_cs_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [c_SHIFT_W-1:0] r_shift;
    logic [4:0]           r_bits;
    logic                 r_in_frame;   // a genuine cs_n fall opened this frame

    logic                 r_pend_valid;
    logic [6:0]           r_pend_cmd;
    logic [7:0]           r_pend_data;

    logic [1:0]           r_state;
    logic [c_PH_W-1:0]    r_phase;

    logic [15:0]          r_echo;
    logic [15:0]          r_miso_sh;    // remaining echo bits, next one at MSB

    logic                 w_take;
    logic [c_SHIFT_W-1:0] w_frame;
    logic [4:0]           w_bits;
    logic                 w_close;
    logic                 w_parity_ok;
    logic                 w_good;
    logic                 w_pop;
    logic                 w_overrun;
    logic                 w_push;
    logic                 w_reject;
    logic                 w_echo_msb;

    // Shift/count as they will be after this cycle's sclk rise (if any),
    // so a frame closing in the same cycle sees its last bit.
    assign w_take  = r_sclk_rise & r_cs_was_low;
    assign w_frame = w_take ? {r_shift[c_SHIFT_W-2:0], r_mosi_q} : r_shift;
    assign w_bits  = !w_take                ? r_bits :
                     (r_bits == c_BITS_SAT) ? c_BITS_SAT :
                                              r_bits + 5'd1;

    // A cs_n rise after reset without a matching fall is the tail of an
    // aborted frame and is dropped silently.
    assign w_close = r_cs_rise & r_in_frame;

`ifdef SPI_CMD_PARITY_EN
    assign w_parity_ok = ~(^w_frame[15:8]);
    assign w_echo_msb  = ^r_pend_cmd;
`else
    assign w_parity_ok = 1'b1;
    assign w_echo_msb  = 1'b0;
`endif

    assign w_good    = w_close & (w_bits == c_BITS_FULL) & w_parity_ok;
    // IDLE always drains the buffer, so a same-cycle pop frees the slot.
    assign w_pop     = (r_state == c_ST_IDLE) & r_pend_valid;
    assign w_overrun = w_good & r_pend_valid & ~w_pop;
    assign w_push    = w_good & ~w_overrun;
    assign w_reject  = (w_close & ~w_good) | w_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_bits       <= '0;
            r_in_frame   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= '0;
            r_pend_data  <= '0;
            r_state      <= c_ST_IDLE;
            r_phase      <= '0;
            r_echo       <= 16'h0000;
            r_miso_sh    <= 16'h0000;
            command      <= '0;
            data         <= '0;
            enable       <= 1'b0;
            spi_miso     <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            // ---------------- shifter ----------------
            if (r_cs_fall) begin
                r_shift    <= '0;
                r_bits     <= '0;
                r_in_frame <= 1'b1;
            end else begin
                r_shift <= w_frame;
                r_bits  <= w_bits;
                if (r_cs_rise) begin
                    r_in_frame <= 1'b0;
                end
            end

            // ---------------- pending buffer ----------------
            if (w_push) begin
                r_pend_valid <= 1'b1;
                r_pend_cmd   <= w_frame[14:8];
                r_pend_data  <= w_frame[7:0];
            end else if (w_pop) begin
                r_pend_valid <= 1'b0;
            end

            // ---------------- error reporting ----------------
            frame_err <= w_reject;
            if (w_reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // ---------------- output FSM ----------------
            case (r_state)
                c_ST_IDLE: begin
                    if (r_pend_valid) begin
                        command <= r_pend_cmd;
                        data    <= r_pend_data;
                        r_echo  <= {w_echo_msb, r_pend_cmd, r_pend_data};
                        r_phase <= '0;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (r_phase == c_SETUP_LAST) begin
                        r_phase <= '0;
                        enable  <= 1'b1;
                        r_state <= c_ST_STROBE;
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end
                c_ST_STROBE: begin
                    if (r_phase == c_ENABLE_LAST) begin
                        r_phase <= '0;
                        enable  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end
                default: begin
                    r_phase <= '0;
                    enable  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase

            // ---------------- MISO echo ----------------
            // MSB is presented at cs_n fall so the host's first sclk rise
            // samples it; later bits advance on each sclk fall.
            if (r_cs_fall) begin
                spi_miso  <= r_echo[15];
                r_miso_sh <= {r_echo[14:0], 1'b0};
            end else if (!r_in_frame) begin
                spi_miso  <= 1'b0;
            end else if (r_sclk_fall) begin
                spi_miso  <= r_miso_sh[15];
                r_miso_sh <= {r_miso_sh[14:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_cmd_deframer                                        |
// | Description : Directed self-checking bench for spi_cmd_deframer. A       |
// |               second instance with a very long strobe provides the       |
// |               pending-buffer overrun case.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_cmd_deframer;

    localparam int c_HALF = 8;   // clk cycles per host sclk half-period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic sclk  = 1'b0;
    logic mosi  = 1'b0;
    logic cs_n  = 1'b1;
    logic cs_n2 = 1'b1;

    logic       miso1, en1, fe1;
    logic [6:0] cmd1;
    logic [7:0] dat1, ec1;
    logic       miso2, en2, fe2;
    logic [6:0] cmd2;
    logic [7:0] dat2, ec2;

    spi_cmd_deframer u_dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (sclk),
        .spi_mosi  (mosi),
        .spi_cs_n  (cs_n),
        .spi_miso  (miso1),
        .command   (cmd1),
        .data      (dat1),
        .enable    (en1),
        .frame_err (fe1),
        .err_count (ec1)
    );

    spi_cmd_deframer #(
        .SYNC_STAGES   (2),
        .SETUP_CYCLES  (2),
        .ENABLE_CYCLES (1000)
    ) u_dut_long (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (sclk),
        .spi_mosi  (mosi),
        .spi_cs_n  (cs_n2),
        .spi_miso  (miso2),
        .command   (cmd2),
        .data      (dat2),
        .enable    (en2),
        .frame_err (fe2),
        .err_count (ec2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- strobe / error monitor ----------------
    typedef struct packed {
        logic [6:0] c;
        logic [7:0] d;
        logic       stable;   // command/data unchanged for the two cycles before enable rose
    } strobe_t;

    strobe_t     log1[$];
    strobe_t     log2[$];
    int          fe1_cnt = 0;
    int          fe2_cnt = 0;
    logic        en1_p = 1'b0, en2_p = 1'b0;
    logic [14:0] h1a = '0, h1b = '0, h2a = '0, h2b = '0;

    always @(negedge clk) begin
        if (en1 && !en1_p)
            log1.push_back(strobe_t'{c: cmd1, d: dat1,
                                     stable: (h1a == {cmd1, dat1}) && (h1b == {cmd1, dat1})});
        if (en2 && !en2_p)
            log2.push_back(strobe_t'{c: cmd2, d: dat2,
                                     stable: (h2a == {cmd2, dat2}) && (h2b == {cmd2, dat2})});
        h1b = h1a; h1a = {cmd1, dat1}; en1_p = en1;
        h2b = h2a; h2a = {cmd2, dat2}; en2_p = en2;
        if (fe1) fe1_cnt++;
        if (fe2) fe2_cnt++;
    end

    function automatic strobe_t get1(input int i);
        if (i < log1.size()) return log1[i];
        return '0;
    endfunction

    function automatic strobe_t get2(input int i);
        if (i < log2.size()) return log2[i];
        return '0;
    endfunction

    function automatic logic [15:0] mk(input logic [6:0] c, input logic [7:0] d);
`ifdef SPI_CMD_PARITY_EN
        return {^c, c, d};
`else
        return {1'b0, c, d};
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clkn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input bit sel, input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if ((sel ? log2.size() : log1.size()) >= n) break;
            @(negedge clk);
        end
        chk(tag, sel ? log2.size() : log1.size(), n);
    endtask

    // ---------------- SPI host ----------------
    task automatic cs_drive(input bit sel, input logic v);
        if (sel) cs_n2 = v;
        else     cs_n  = v;
    endtask

    task automatic spi_bit(input logic b, input bit sel, output logic m);
        mosi = b;
        clkn(c_HALF);
        sclk = 1'b1;
        m = sel ? miso2 : miso1;
        clkn(c_HALF);
        sclk = 1'b0;
    endtask

    task automatic xfer(input logic [15:0] w, input int nbits, input bit sel,
                        output logic [15:0] rx);
        logic m;
        rx = '0;
        cs_drive(sel, 1'b0);
        clkn(c_HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(w[15-i], sel, m);
            rx = {rx[14:0], m};
        end
        clkn(c_HALF);
        cs_drive(sel, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] rx;
        logic [15:0] w;
        logic        m;
        strobe_t     s;

        // Reset state
        clkn(6);
        chk("rst_command", cmd1, 0);
        chk("rst_data", dat1, 0);
        chk("rst_enable", en1, 0);
        chk("rst_miso", miso1, 0);
        chk("rst_frame_err", fe1, 0);
        chk("rst_err_count", ec1, 0);
        rst = 1'b0;
        clkn(4);

        // Valid frame: cycle-exact latency from cs_n rise
        xfer(mk(7'h02, 8'h05), 16, 1'b0, rx);
        for (int k = 1; k <= 10; k++) begin
            clkn(1);
            chk($sformatf("lat_enable_c%0d", k), en1, (k == 7 || k == 8) ? 1 : 0);
            if (k == 4) chk("lat_command_c4", cmd1, 7'h00);
            if (k == 5) begin
                chk("lat_command_c5", cmd1, 7'h02);
                chk("lat_data_c5", dat1, 8'h05);
            end
        end
        chk("valid_no_frame_err", fe1_cnt, 0);
        s = get1(0);
        chk("valid_setup_stable", s.stable, 1);

        // Short 8-bit frame, then saturation of err_count
        xfer({8'h03, 8'h00}, 8, 1'b0, rx);
        clkn(20);
        chk("short_no_strobe", log1.size(), 1);
        chk("short_frame_err", fe1_cnt, 1);
        chk("short_err_count", ec1, 1);
        repeat (300) begin
            cs_n = 1'b0; clkn(4);
            cs_n = 1'b1; clkn(4);
        end
        clkn(10);
        chk("sat_err_count", ec1, 255);
        chk("sat_frame_err_pulses", fe1_cnt, 301);
        chk("sat_no_strobe", log1.size(), 1);

        // Back-to-back valid frames with minimum cs_n gap
        xfer(mk(7'h04, 8'h10), 16, 1'b0, rx);
        clkn(4);
        xfer(mk(7'h05, 8'h11), 16, 1'b0, rx);
        wait_log(1'b0, 3, 200, "b2b_strobe_count");
        s = get1(1);
        chk("b2b_first_cmd", s.c, 7'h04);
        chk("b2b_first_data", s.d, 8'h10);
        chk("b2b_first_stable", s.stable, 1);
        s = get1(2);
        chk("b2b_second_cmd", s.c, 7'h05);
        chk("b2b_second_data", s.d, 8'h11);
        chk("b2b_second_stable", s.stable, 1);

        // Overrun: long-strobe instance, third frame arrives with buffer full
        xfer(mk(7'h04, 8'h10), 16, 1'b1, rx);
        clkn(4);
        xfer(mk(7'h05, 8'h11), 16, 1'b1, rx);
        clkn(4);
        xfer(mk(7'h06, 8'h12), 16, 1'b1, rx);
        clkn(20);
        chk("ovr_frame_err", fe2_cnt, 1);
        chk("ovr_err_count", ec2, 1);
        wait_log(1'b1, 2, 3000, "ovr_strobe_count");
        s = get2(0);
        chk("ovr_first_cmd", s.c, 7'h04);
        s = get2(1);
        chk("ovr_second_cmd", s.c, 7'h05);
        chk("ovr_second_data", s.d, 8'h11);
        clkn(1100);
        chk("ovr_third_dropped", log2.size(), 2);

        // Reset after bit 9 of a frame; the host finishes the frame anyway
        w = mk(7'h03, 8'h01);
        cs_n = 1'b0;
        clkn(c_HALF);
        for (int i = 0; i < 9; i++) spi_bit(w[15-i], 1'b0, m);
        rst = 1'b1;
        clkn(2);
        rst = 1'b0;
        for (int i = 9; i < 16; i++) spi_bit(w[15-i], 1'b0, m);
        clkn(c_HALF);
        cs_n = 1'b1;
        clkn(30);
        chk("abort_no_strobe", log1.size(), 3);
        chk("abort_err_count", ec1, 0);
        chk("abort_no_frame_err", fe1_cnt, 301);
        xfer(mk(7'h03, 8'h02), 16, 1'b0, rx);
        chk("abort_echo_cleared", rx, 16'h0000);
        wait_log(1'b0, 4, 100, "abort_next_strobe");
        s = get1(3);
        chk("abort_next_cmd", s.c, 7'h03);
        chk("abort_next_data", s.d, 8'h02);

        // MISO echo of the previously accepted frame
        xfer(mk(7'h02, 8'h22), 16, 1'b0, rx);
        chk("echo_0302", rx, mk(7'h03, 8'h02));
        wait_log(1'b0, 5, 100, "echo_strobe");
        clkn(10);
        xfer(mk(7'h00, 8'h00), 16, 1'b0, rx);
        chk("echo_0222", rx, mk(7'h02, 8'h22));
        wait_log(1'b0, 6, 100, "echo_zero_strobe");
        clkn(10);
        chk("miso_idle_low", miso1, 0);

`ifdef SPI_CMD_PARITY_EN
        // Parity: 0x81 has even popcount, 0x01 odd
        xfer(16'h8107, 16, 1'b0, rx);
        wait_log(1'b0, 7, 100, "par_good_strobe");
        s = get1(6);
        chk("par_good_cmd", s.c, 7'h01);
        chk("par_good_data", s.d, 8'h07);
        xfer(16'h0107, 16, 1'b0, rx);
        clkn(20);
        chk("par_bad_frame_err", fe1_cnt, 302);
        chk("par_bad_err_count", ec1, 1);
        chk("par_bad_no_strobe", log1.size(), 7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish (observed running, expected done)");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
